// File: rtl/aes_round_key_gen_if.sv
// Command and round-key stream bundle for the AES key schedule.
// master: cipher-side controller (issues start, consumes round keys).
// slave : the key schedule generator.
interface aes_round_key_gen_if;
  logic         start;
  logic [255:0] key;
  logic [3:0]   Nr;
  logic         busy;
  logic         done;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk_data;
  logic [3:0]   rk_index;

  modport master (
    output start, key, Nr, rk_ready,
    input  busy, done, rk_valid, rk_data, rk_index
  );

  modport slave (
    input  start, key, Nr, rk_ready,
    output busy, done, rk_valid, rk_data, rk_index
  );
endinterface

// File: rtl/aes_round_key_gen.sv
// Iterative AES-128/192/256 key schedule. One 32-bit schedule word per
// cycle through a single 32-bit S-box; every fourth word completes a
// round key that is offered on a valid/ready stream, round 0 first.
module aes_round_key_gen (
  input  logic              clk,
  input  logic              reset,
  aes_round_key_gen_if.slave bus
);

  typedef enum logic [1:0] {IDLE, GEN, DRAIN} state_t;

  // Forward S-box, entry 0 first (0x00 -> 0x63).
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  state_t            state_q,    state_d;
  logic [3:0]        nk_q,       nk_d;        // key length in words: 4/6/8
  logic [3:0]        nr_q,       nr_d;        // effective round count
  logic [0:7][31:0]  win_q,      win_d;       // word window, [7] newest
  logic [0:2][31:0]  asm_q,      asm_d;       // words 0..2 of current key
  logic [5:0]        i_q,        i_d;         // schedule word index
  logic [2:0]        mod_q,      mod_d;       // i mod Nk
  logic [7:0]        rcon_q,     rcon_d;
  logic [127:0]      rk_data_q,  rk_data_d;
  logic [3:0]        rk_index_q, rk_index_d;
  logic              rk_valid_q, rk_valid_d;
  logic              busy_q,     busy_d;
  logic              done_q,     done_d;

  logic [2:0]  old_pos;    // window slot of w[i-Nk]
  logic [2:0]  key_pos;    // window slot of cipher-key word i (i < Nk)
  logic [31:0] prev_w, old_w, sub_in, sub_out, new_w;
  logic        past_key, key_last, handshake, stall;

  // Word datapath: w[i] from the window through the shared S-box.
  always_comb begin
    old_pos  = 3'(4'd8 - nk_q);
    key_pos  = old_pos + i_q[2:0];
    prev_w   = win_q[7];
    old_w    = win_q[old_pos];
    past_key = (i_q >= {2'b00, nk_q});
    sub_in   = (mod_q == 3'd0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;
    sub_out  = sub_word(sub_in);
    if (!past_key)                           new_w = win_q[key_pos];
    else if (mod_q == 3'd0)                  new_w = old_w ^ sub_out ^ {rcon_q, 24'h0};
    else if (nk_q == 4'd8 && mod_q == 3'd4)  new_w = old_w ^ sub_out;
    else                                     new_w = old_w ^ prev_w;
    key_last  = (i_q[1:0] == 2'b11);
    handshake = rk_valid_q && bus.rk_ready;
    stall     = key_last && rk_valid_q && !bus.rk_ready;
  end

  // Control FSM and next-state for all schedule and output registers.
  always_comb begin
    // NOTE: every _d starts as its _q so no path through the case leaves a
    // variable unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    nk_d       = nk_q;
    nr_d       = nr_q;
    win_d      = win_q;
    asm_d      = asm_q;
    i_d        = i_q;
    mod_d      = mod_q;
    rcon_d     = rcon_q;
    rk_data_d  = rk_data_q;
    rk_index_d = rk_index_q;
    rk_valid_d = rk_valid_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          // Key words are right-aligned so the window always ends in w[Nk-1].
          unique case (bus.Nr)
            4'd10: begin
              nk_d  = 4'd4;
              nr_d  = 4'd10;
              win_d = {128'h0, bus.key[255:128]};
            end
            4'd12: begin
              nk_d  = 4'd6;
              nr_d  = 4'd12;
              win_d = {64'h0, bus.key[255:64]};
            end
            default: begin
              nk_d  = 4'd8;
              nr_d  = 4'd14;
              win_d = bus.key;
            end
          endcase
          i_d     = 6'd0;
          mod_d   = 3'd0;
          rcon_d  = 8'h01;
          busy_d  = 1'b1;
          state_d = GEN;
        end
      end

      GEN: begin
        if (handshake) rk_valid_d = 1'b0;
        // Words 0..2 of the next key keep flowing while the output is held;
        // only the completing word waits for the pending key to be taken.
        if (!stall) begin
          i_d   = i_q + 6'd1;
          mod_d = (mod_q == 3'(nk_q - 4'd1)) ? 3'd0 : mod_q + 3'd1;
          if (past_key) begin
            win_d = {win_q[1:7], new_w};
            if (mod_q == 3'd0) rcon_d = xtime(rcon_q);
          end
          if (key_last) begin
            rk_data_d  = {asm_q, new_w};
            rk_index_d = i_q[5:2];
            rk_valid_d = 1'b1;
            if (i_q == {nr_q, 2'b11}) state_d = DRAIN;
          end else begin
            unique case (i_q[1:0])
              2'd0:    asm_d[0] = new_w;
              2'd1:    asm_d[1] = new_w;
              default: asm_d[2] = new_w;
            endcase
          end
        end
      end

      DRAIN: begin
        if (handshake) begin
          rk_valid_d = 1'b0;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          state_d    = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State registers; reset aborts any expansion in progress.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      nk_q       <= '0;
      nr_q       <= '0;
      // NOTE: the window is a handful of flops, not a RAM, so it is cleared
      // with the rest of the state instead of being left unreset.
      win_q      <= '0;
      asm_q      <= '0;
      i_q        <= '0;
      mod_q      <= '0;
      rcon_q     <= '0;
      rk_data_q  <= '0;
      rk_index_q <= '0;
      rk_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every flop samples pre-edge values.
      state_q    <= state_d;
      nk_q       <= nk_d;
      nr_q       <= nr_d;
      win_q      <= win_d;
      asm_q      <= asm_d;
      i_q        <= i_d;
      mod_q      <= mod_d;
      rcon_q     <= rcon_d;
      rk_data_q  <= rk_data_d;
      rk_index_q <= rk_index_d;
      rk_valid_q <= rk_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.rk_valid = rk_valid_q;
  assign bus.rk_data  = rk_data_q;
  assign bus.rk_index = rk_index_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_aes_round_key_gen.sv
// Directed bench for aes_round_key_gen using FIPS-197 key expansion vectors.
module tb_aes_round_key_gen;

  localparam logic [127:0] KEY128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [191:0] KEY192 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [255:0] KEY256 =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  localparam logic [127:0] EXP128 [0:10] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  logic clk = 1'b0;
  logic reset;
  aes_round_key_gen_if bus ();

  aes_round_key_gen dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  // Results of the most recent expansion run.
  logic [127:0] got_data [15];
  logic [3:0]   got_idx  [15];
  int           got_edge [15];
  int           n_got, stab_err, done_edge;
  logic         busy_e0, busy_done;
  bit           timed_out;

  // Pulse start, then act as the consumer from negedge to negedge. Edge
  // numbers are counted from the edge that samples start (E0).
  task automatic run_expansion(input logic [255:0] k, input logic [3:0] nr,
                               input int ready_pct, input int stop_after,
                               input int glitch_t);
    int c0;
    logic pend;
    logic [127:0] pend_data;
    logic [3:0] pend_idx;
    n_got = 0; stab_err = 0; done_edge = -1; timed_out = 0;
    pend = 1'b0; pend_data = '0; pend_idx = '0; busy_done = 1'bx;
    for (int j = 0; j < 15; j++) begin
      got_data[j] = 'x; got_idx[j] = 'x; got_edge[j] = -1;
    end
    @(negedge clk);
    bus.key = k; bus.Nr = nr; bus.start = 1'b1; bus.rk_ready = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    c0 = cyc;
    busy_e0 = bus.busy;
    for (int t = 0; ; t++) begin
      if (t >= 2000) begin timed_out = 1; break; end
      if (pend && (bus.rk_valid !== 1'b1 || bus.rk_data !== pend_data ||
                   bus.rk_index !== pend_idx)) stab_err++;
      if (bus.done === 1'b1) begin
        done_edge = cyc - c0; busy_done = bus.busy; break;
      end
      if (t == glitch_t) begin
        bus.start = 1'b1; bus.key = ~k; bus.Nr = (nr == 4'd10) ? 4'd14 : 4'd10;
      end else begin
        bus.start = 1'b0;
      end
      bus.rk_ready = (int'($urandom_range(99)) < ready_pct);
      if (bus.rk_valid === 1'b1 && bus.rk_ready) begin
        if (n_got < 15) begin
          got_data[n_got] = bus.rk_data;
          got_idx[n_got]  = bus.rk_index;
          got_edge[n_got] = cyc - c0;
        end
        n_got++;
        if (stop_after > 0 && n_got >= stop_after) break;
      end
      pend = (bus.rk_valid === 1'b1) && !bus.rk_ready;
      pend_data = bus.rk_data;
      pend_idx  = bus.rk_index;
      @(negedge clk);
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    for (int ph = 0; ph < 2; ph++) begin
      n_checks++; if (bus.rk_valid !== 1'b0) $display("FAIL reset_rk_valid[%0d]: got %b expected 0", ph, bus.rk_valid); else n_pass++;
      n_checks++; if (bus.rk_data !== 128'h0) $display("FAIL reset_rk_data[%0d]: got %h expected 0", ph, bus.rk_data); else n_pass++;
      n_checks++; if (bus.rk_index !== 4'h0) $display("FAIL reset_rk_index[%0d]: got %h expected 0", ph, bus.rk_index); else n_pass++;
      n_checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy[%0d]: got %b expected 0", ph, bus.busy); else n_pass++;
      n_checks++; if (bus.done !== 1'b0) $display("FAIL reset_done[%0d]: got %b expected 0", ph, bus.done); else n_pass++;
      reset = 1'b1;
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic test_aes128;
    run_expansion({KEY128, 128'h0}, 4'd10, 100, 0, -1);
    n_checks++; if (timed_out) $display("FAIL aes128_timeout: got timeout expected done"); else n_pass++;
    n_checks++; if (busy_e0 !== 1'b1) $display("FAIL aes128_busy_e0: got %b expected 1", busy_e0); else n_pass++;
    n_checks++; if (n_got != 11) $display("FAIL aes128_count: got %0d expected 11", n_got); else n_pass++;
    for (int r = 0; r < 11; r++) begin
      n_checks++; if (got_idx[r] !== 4'(r)) $display("FAIL aes128_idx[%0d]: got %h expected %h", r, got_idx[r], 4'(r)); else n_pass++;
      n_checks++; if (got_data[r] !== EXP128[r]) $display("FAIL aes128_key[%0d]: got %h expected %h", r, got_data[r], EXP128[r]); else n_pass++;
    end
    n_checks++; if (got_edge[0] != 4) $display("FAIL aes128_edge0: got %0d expected 4", got_edge[0]); else n_pass++;
    n_checks++; if (got_edge[10] != 44) $display("FAIL aes128_edge10: got %0d expected 44", got_edge[10]); else n_pass++;
    n_checks++; if (done_edge != 45) $display("FAIL aes128_done_edge: got %0d expected 45", done_edge); else n_pass++;
    n_checks++; if (busy_done !== 1'b0) $display("FAIL aes128_busy_at_done: got %b expected 0", busy_done); else n_pass++;
    @(negedge clk);
    n_checks++; if (bus.done !== 1'b0) $display("FAIL aes128_done_width: got %b expected 0", bus.done); else n_pass++;
  endtask

  task automatic test_aes192;
    run_expansion({KEY192, 64'h0}, 4'd12, 100, 0, -1);
    n_checks++; if (n_got != 13) $display("FAIL aes192_count: got %0d expected 13", n_got); else n_pass++;
    n_checks++; if (got_data[0] !== KEY192[191:64]) $display("FAIL aes192_key0: got %h expected %h", got_data[0], KEY192[191:64]); else n_pass++;
    n_checks++; if (got_data[1][63:32] !== 32'hfe0c91f7) $display("FAIL aes192_w6: got %h expected fe0c91f7", got_data[1][63:32]); else n_pass++;
    n_checks++; if (got_idx[12] !== 4'd12) $display("FAIL aes192_idx12: got %h expected c", got_idx[12]); else n_pass++;
    n_checks++; if (got_data[12] !== 128'he98ba06f448c773c8ecc720401002202) $display("FAIL aes192_key12: got %h expected e98ba06f448c773c8ecc720401002202", got_data[12]); else n_pass++;
    n_checks++; if (got_edge[12] != 52) $display("FAIL aes192_edge12: got %0d expected 52", got_edge[12]); else n_pass++;
  endtask

  task automatic check_aes256(input string tag);
    n_checks++; if (n_got != 15) $display("FAIL %s_count: got %0d expected 15", tag, n_got); else n_pass++;
    n_checks++; if (got_data[1] !== KEY256[127:0]) $display("FAIL %s_key1: got %h expected %h", tag, got_data[1], KEY256[127:0]); else n_pass++;
    n_checks++; if (got_data[2][127:96] !== 32'h9ba35411) $display("FAIL %s_w8: got %h expected 9ba35411", tag, got_data[2][127:96]); else n_pass++;
    n_checks++; if (got_idx[14] !== 4'd14) $display("FAIL %s_idx14: got %h expected e", tag, got_idx[14]); else n_pass++;
    n_checks++; if (got_data[14] !== 128'hfe4890d1e6188d0b046df344706c631e) $display("FAIL %s_key14: got %h expected fe4890d1e6188d0b046df344706c631e", tag, got_data[14]); else n_pass++;
    n_checks++; if (got_edge[14] != 60) $display("FAIL %s_edge14: got %0d expected 60", tag, got_edge[14]); else n_pass++;
    n_checks++; if (done_edge != 61) $display("FAIL %s_done_edge: got %0d expected 61", tag, done_edge); else n_pass++;
  endtask

  task automatic test_aes256;
    run_expansion(KEY256, 4'd14, 100, 0, -1);
    check_aes256("aes256");
    run_expansion(KEY256, 4'd15, 100, 0, -1);
    check_aes256("nr15");
  endtask

  task automatic test_backpressure;
    run_expansion({KEY128, 128'h0}, 4'd10, 30, 0, -1);
    n_checks++; if (timed_out) $display("FAIL bp_timeout: got timeout expected done"); else n_pass++;
    n_checks++; if (n_got != 11) $display("FAIL bp_count: got %0d expected 11", n_got); else n_pass++;
    n_checks++; if (stab_err != 0) $display("FAIL bp_stable: got %0d changes expected 0", stab_err); else n_pass++;
    for (int r = 0; r < 11; r++) begin
      n_checks++; if (got_idx[r] !== 4'(r) || got_data[r] !== EXP128[r])
        $display("FAIL bp_key[%0d]: got %h/%h expected %h/%h", r, got_idx[r], got_data[r], 4'(r), EXP128[r]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid;
    int seen;
    seen = 0;
    run_expansion({KEY128, 128'h0}, 4'd10, 100, 4, -1);
    n_checks++; if (got_idx[3] !== 4'd3) $display("FAIL rstmid_idx3: got %h expected 3", got_idx[3]); else n_pass++;
    reset = 1'b0;
    #1;
    n_checks++; if (bus.rk_valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0)
      $display("FAIL rstmid_flags: got valid=%b busy=%b done=%b expected 0/0/0", bus.rk_valid, bus.busy, bus.done);
    else n_pass++;
    n_checks++; if (bus.rk_data !== 128'h0 || bus.rk_index !== 4'h0)
      $display("FAIL rstmid_data: got %h/%h expected 0/0", bus.rk_data, bus.rk_index);
    else n_pass++;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.rk_valid !== 1'b0) seen++;
    end
    n_checks++; if (seen != 0) $display("FAIL rstmid_no_done: got %0d active cycles expected 0", seen); else n_pass++;
    run_expansion({KEY128, 128'h0}, 4'd10, 100, 0, -1);
    n_checks++; if (got_idx[0] !== 4'd0 || got_data[0] !== EXP128[0])
      $display("FAIL rstmid_rerun0: got %h/%h expected 0/%h", got_idx[0], got_data[0], EXP128[0]);
    else n_pass++;
    n_checks++; if (n_got != 11 || got_data[10] !== EXP128[10])
      $display("FAIL rstmid_rerun10: got %0d keys last %h expected 11 keys last %h", n_got, got_data[10], EXP128[10]);
    else n_pass++;
  endtask

  task automatic test_start_while_busy;
    run_expansion({KEY128, 128'h0}, 4'd10, 100, 0, 10);
    n_checks++; if (n_got != 11) $display("FAIL busy_start_count: got %0d expected 11", n_got); else n_pass++;
    for (int r = 0; r < 11; r++) begin
      n_checks++; if (got_idx[r] !== 4'(r) || got_data[r] !== EXP128[r])
        $display("FAIL busy_start_key[%0d]: got %h/%h expected %h/%h", r, got_idx[r], got_data[r], 4'(r), EXP128[r]);
      else n_pass++;
    end
    n_checks++; if (done_edge != 45) $display("FAIL busy_start_done_edge: got %0d expected 45", done_edge); else n_pass++;
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.key      = '0;
    bus.Nr       = '0;
    bus.rk_ready = 1'b0;
    reset        = 1'b0;
    test_reset;
    test_aes128;
    test_aes192;
    test_aes256;
    test_backpressure;
    test_reset_mid;
    test_start_while_busy;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
